// File: rtl/pwm_capture_block.sv
// Purpose: measures period and high time of an asynchronous PWM input, exposed
//   as a small USI register block (CTRL/STATUS/PERIOD/HIGH/COUNT).
// Latency: read data one cycle after the address; PWM edges seen 2 cycles after
//   iPwm changes (4 cycles when PWM_CAPTURE_FILTER_EN is defined).
// Backpressure: none; reads and writes complete every cycle.
//
// Ports:
//   iSysClk, iSysRst : system clock, synchronous active-high reset
//   iPwm             : asynchronous PWM input
//   iSUsiWd/iSUsiAdrs/iSUsiWCke : USI write data, address, write strobe
//   oSUsiRd/oSUsiREd : registered USI read data and read-data valid
//
// Optional build macro: PWM_CAPTURE_FILTER_EN adds a 3-sample majority filter
// after the synchronizer that rejects pulses of one cycle or less.
module pwm_capture_block #(
  parameter int pBlockAdrsMap = 8,
  parameter int pAdrsMap      = 3,
  parameter int pBusAdrsBit   = 15
) (
  input  logic                   iSysClk,
  input  logic                   iSysRst,
  input  logic                   iPwm,
  input  logic [31:0]            iSUsiWd,
  input  logic [pBusAdrsBit:0]   iSUsiAdrs,
  input  logic                   iSUsiWCke,
  output logic [31:0]            oSUsiRd,
  output logic                   oSUsiREd
);

  localparam int blockLsb = pBusAdrsBit - pBlockAdrsMap + 1;
  localparam logic [pBlockAdrsMap-1:0] blockId = pBlockAdrsMap'(pAdrsMap);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t      state, stateNext;

  logic        blkSel;
  logic [7:0]  regOfs;
  logic        ctrlWr;
  logic        clearPulse;
  logic        enable;

  logic        sync1, sync2;
  logic        pwmLvl, pwmPrev;
  logic        riseEdge, fallEdge;

  logic [15:0] cnt;
  logic [15:0] highCnt;
  logic [15:0] periodReg;
  logic [15:0] highReg;
  logic [15:0] captureCount;
  logic        valid;
  logic        stall;

  logic        capture;
  logic        saturate;
  logic        startCnt;
  logic [31:0] rdVal;

  // Only CTRL bits [1:0] carry meaning.
  wire unusedWd = ^iSUsiWd[31:2];

  // ---------------------------------------------------------------- bus decode
  assign blkSel     = (iSUsiAdrs[pBusAdrsBit:blockLsb] == blockId);
  assign regOfs     = iSUsiAdrs[7:0];
  assign ctrlWr     = iSUsiWCke && blkSel && (regOfs == 8'h00);
  // Clear is never stored: it acts in the write cycle only, so CTRL[1] reads 0.
  assign clearPulse = ctrlWr && iSUsiWd[1];

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      enable <= 1'b0;
    end else if (ctrlWr) begin
      enable <= iSUsiWd[0];
    end
  end

  // ------------------------------------------------------- input conditioning
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      pwmPrev <= 1'b0;
    end else begin
      sync1   <= iPwm;
      sync2   <= sync1;
      pwmPrev <= pwmLvl;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  // Majority of the current and two previous synchronized samples, registered.
  // A single-cycle pulse never occupies two of the three taps at once.
  logic [1:0] hist;
  logic       filtLvl;

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      hist    <= 2'b00;
      filtLvl <= 1'b0;
    end else begin
      hist    <= {hist[0], sync2};
      filtLvl <= (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
    end
  end

  assign pwmLvl = filtLvl;
`else
  assign pwmLvl = sync2;
`endif

  assign riseEdge = pwmLvl & ~pwmPrev;
  assign fallEdge = ~pwmLvl & pwmPrev;

  // ---------------------------------------------------------------------- FSM
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    capture   = 1'b0;
    saturate  = 1'b0;
    startCnt  = 1'b0;
    if (!enable) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: stateNext = ARM;
        ARM: begin
          if (riseEdge) begin
            stateNext = MEASURE;
            startCnt  = 1'b1;
          end
        end
        MEASURE: begin
          // A rising edge on the saturating cycle still yields a valid capture.
          if (riseEdge) begin
            capture = 1'b1;
          end else if (cnt == 16'hFFFF) begin
            saturate  = 1'b1;
            stateNext = ARM;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      cnt          <= 16'd0;
      highCnt      <= 16'd0;
      periodReg    <= 16'd0;
      highReg      <= 16'd0;
      captureCount <= 16'd0;
      valid        <= 1'b0;
      stall        <= 1'b0;
    end else begin
      if (startCnt || capture) begin
        cnt <= 16'd1;
      end else if (state == MEASURE && stateNext == MEASURE) begin
        cnt <= cnt + 16'd1;
      end

      if (state == MEASURE && enable && fallEdge) begin
        highCnt <= cnt;
      end

      if (capture) begin
        periodReg    <= cnt;
        highReg      <= highCnt;
        captureCount <= captureCount + 16'd1;
      end

      // Sticky flags: a same-cycle event beats a clear.
      if (capture) begin
        valid <= 1'b1;
      end else if (clearPulse) begin
        valid <= 1'b0;
      end

      if (saturate) begin
        stall <= 1'b1;
      end else if (clearPulse) begin
        stall <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- read path
  always_comb begin
    rdVal = 32'd0;
    case (regOfs)
      8'h00:   rdVal = {31'd0, enable};
      8'h04:   rdVal = {29'd0, pwmLvl, stall, valid};
      8'h08:   rdVal = {16'd0, periodReg};
      8'h0C:   rdVal = {16'd0, highReg};
      8'h10:   rdVal = {16'd0, captureCount};
      default: rdVal = 32'd0;
    endcase
  end

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      oSUsiRd  <= 32'd0;
      oSUsiREd <= 1'b0;
    end else begin
      oSUsiREd <= blkSel;
      oSUsiRd  <= blkSel ? rdVal : 32'd0;
    end
  end

endmodule

// File: tb/tb_pwm_capture_block.sv
// Purpose: directed self-checking bench for pwm_capture_block.
// Latency: inputs driven 1 time unit after each rising clock edge; outputs
//   checked at that same point, i.e. away from the active edge.
// Backpressure: not applicable.
module tb_pwm_capture_block;

  logic        iSysClk = 1'b0;
  logic        iSysRst;
  logic        iPwm;
  logic [31:0] iSUsiWd;
  logic [15:0] iSUsiAdrs;
  logic        iSUsiWCke;
  logic [31:0] oSUsiRd;
  logic        oSUsiREd;

  int checks   = 0;
  int failures = 0;

  pwm_capture_block dut (
    .iSysClk  (iSysClk),
    .iSysRst  (iSysRst),
    .iPwm     (iPwm),
    .iSUsiWd  (iSUsiWd),
    .iSUsiAdrs(iSUsiAdrs),
    .iSUsiWCke(iSUsiWCke),
    .oSUsiRd  (oSUsiRd),
    .oSUsiREd (oSUsiREd)
  );

  always #5 iSysClk = ~iSysClk;

  typedef struct {
    logic [15:0] adrs;
    logic [31:0] wd;
    logic        wcke;
    logic        expREd;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge iSysClk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rdChk(input logic [15:0] adrs, input logic [31:0] exp, input string name);
    iSUsiAdrs = adrs;
    step();
    check({name, " rdvalid"}, {31'd0, oSUsiREd}, 32'd1);
    check(name, oSUsiRd, exp);
    iSUsiAdrs = 16'h0000;
  endtask

  task automatic wrReg(input logic [15:0] adrs, input logic [31:0] data);
    iSUsiAdrs = adrs;
    iSUsiWd   = data;
    iSUsiWCke = 1'b1;
    step();
    iSUsiWCke = 1'b0;
    iSUsiAdrs = 16'h0000;
    iSUsiWd   = 32'd0;
  endtask

  task automatic pwmRun(input int period, input int high, input int nPeriods);
    for (int p = 0; p < nPeriods; p++) begin
      for (int c = 0; c < period; c++) begin
        iPwm = (c < high);
        step();
      end
    end
    iPwm = 1'b0;
  endtask

  initial begin
    iSysRst   = 1'b1;
    iPwm      = 1'b0;
    iSUsiWd   = 32'd0;
    iSUsiAdrs = 16'h0000;
    iSUsiWCke = 1'b0;

    // table: address, write data, strobe, expected read valid, expected data
    vecs[0]  = '{16'h0304, 32'd0, 1'b0, 1'b1, 32'd0};
    vecs[1]  = '{16'h0308, 32'd0, 1'b0, 1'b1, 32'd0};
    vecs[2]  = '{16'h0310, 32'd0, 1'b0, 1'b1, 32'd0};
    vecs[3]  = '{16'h030C, 32'd0, 1'b0, 1'b1, 32'd0};
    vecs[4]  = '{16'h0314, 32'd0, 1'b0, 1'b1, 32'd0};
    vecs[5]  = '{16'h0200, 32'd0, 1'b0, 1'b0, 32'd0};
    vecs[6]  = '{16'h0300, 32'd1, 1'b1, 1'b1, 32'd0};
    vecs[7]  = '{16'h0300, 32'd0, 1'b0, 1'b1, 32'd1};
    vecs[8]  = '{16'h0200, 32'd0, 1'b1, 1'b0, 32'd0};
    vecs[9]  = '{16'h0308, 32'd0, 1'b1, 1'b1, 32'd0};
    vecs[10] = '{16'h0300, 32'd0, 1'b0, 1'b1, 32'd1};
    vecs[11] = '{16'h0300, 32'd2, 1'b1, 1'b1, 32'd1};
    vecs[12] = '{16'h0300, 32'd0, 1'b0, 1'b1, 32'd0};
    vecs[13] = '{16'h0304, 32'd0, 1'b0, 1'b1, 32'd0};

    step();
    step();
    check("reset rdvalid", {31'd0, oSUsiREd}, 32'd0);
    check("reset rddata", oSUsiRd, 32'd0);
    iSysRst = 1'b0;
    step();

    // ---- register access table
    for (int i = 0; i < 14; i++) begin
      iSUsiAdrs = vecs[i].adrs;
      iSUsiWd   = vecs[i].wd;
      iSUsiWCke = vecs[i].wcke;
      step();
      check($sformatf("vec%0d rdvalid", i), {31'd0, oSUsiREd}, {31'd0, vecs[i].expREd});
      check($sformatf("vec%0d rddata", i), oSUsiRd, vecs[i].expRd);
    end
    iSUsiWCke = 1'b0;
    iSUsiAdrs = 16'h0000;
    iSUsiWd   = 32'd0;

    // ---- 100-cycle period, 5 high, 4 periods
    wrReg(16'h0300, 32'd1);
    step();
    pwmRun(100, 5, 4);
    rdChk(16'h0308, 32'd100, "period100");
    rdChk(16'h030C, 32'd5,   "high5");
    rdChk(16'h0310, 32'd3,   "count3");
    rdChk(16'h0304, 32'd1,   "status valid");

    // ---- clear coinciding with a capturing rising edge
    wrReg(16'h0300, 32'd3);
    rdChk(16'h0304, 32'd0, "status after clear");
    iPwm = 1'b1;
    step();
    step();
`ifdef PWM_CAPTURE_FILTER_EN
    step();
    step();
`endif
    wrReg(16'h0300, 32'd3);
    step();
    step();
    iPwm = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rdChk(16'h0304, 32'd1, "capture beats clear");
    rdChk(16'h0310, 32'd4, "count4");
    wrReg(16'h0300, 32'd3);
    rdChk(16'h0304, 32'd0, "clear without edge");

    // ---- saturation stall then recovery
    pwmRun(100, 5, 3);
    for (int i = 0; i < 70000; i++) step();
    rdChk(16'h0304, 32'd3,   "stall status");
    rdChk(16'h0308, 32'd100, "period kept on stall");
    rdChk(16'h030C, 32'd5,   "high kept on stall");
    pwmRun(60, 10, 3);
    rdChk(16'h0308, 32'd60, "period after resume");
    rdChk(16'h030C, 32'd10, "high after resume");

    // ---- reset in the middle of an edge
    iPwm = 1'b1;
    step();
    step();
    iSysRst = 1'b1;
    iPwm    = 1'b0;
    step();
    iSysRst = 1'b0;
    check("midreset rdvalid", {31'd0, oSUsiREd}, 32'd0);
    rdChk(16'h0308, 32'd0, "midreset period");
    rdChk(16'h030C, 32'd0, "midreset high");
    rdChk(16'h0310, 32'd0, "midreset count");
    rdChk(16'h0304, 32'd0, "midreset status");
    rdChk(16'h0300, 32'd0, "midreset ctrl");

    // ---- 1-cycle pulses every 50 cycles
    wrReg(16'h0300, 32'd1);
    step();
    pwmRun(50, 1, 4);
`ifdef PWM_CAPTURE_FILTER_EN
    rdChk(16'h0310, 32'd0, "filtered count");
    rdChk(16'h0304, 32'd0, "filtered status");
`else
    rdChk(16'h0308, 32'd50, "pulse period");
    rdChk(16'h030C, 32'd1,  "pulse high");
    rdChk(16'h0310, 32'd3,  "pulse count");
`endif

    // ---- disable keeps results
    wrReg(16'h0300, 32'd0);
    rdChk(16'h0300, 32'd0, "disabled ctrl");
`ifndef PWM_CAPTURE_FILTER_EN
    rdChk(16'h0308, 32'd50, "period kept on disable");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture_block.md
PWM_CAPTURE_BLOCK -- requirements
Module: pwm_capture_block

Interface
REQ-001 The block SHALL have parameter pBlockAdrsMap, default 8: width of the block-select field of iSUsiAdrs.
REQ-002 The block SHALL have parameter pAdrsMap, default 3: block-select value that maps this block.
REQ-003 The block SHALL have parameter pBusAdrsBit, default 15: MSB index of iSUsiAdrs.
REQ-004 iSysClk  in  1  single system clock; all logic on its rising edge.
REQ-005 iSysRst  in  1  synchronous, active-high reset.
REQ-006 iPwm  in  1  asynchronous PWM input to be measured.
REQ-007 iSUsiWd  in  32  USI write data.
REQ-008 iSUsiAdrs  in  pBusAdrsBit+1  USI address.
REQ-009 iSUsiWCke  in  1  USI write strobe, one cycle per write.
REQ-010 oSUsiRd  out  32  USI read data.
REQ-011 oSUsiREd  out  1  USI read-data valid.

Function
REQ-012 Block select SHALL be iSUsiAdrs[pBusAdrsBit : pBusAdrsBit-pBlockAdrsMap+1] == pAdrsMap; the register offset SHALL be iSUsiAdrs[7:0].
REQ-013 Register map SHALL be: 0x00 CTRL (RW; [0] enable, [1] clear, write-1 self-clearing, reads 0); 0x04 STATUS (RO; [0] valid, [1] stall, [2] synced level); 0x08 PERIOD (RO [15:0]); 0x0C HIGH (RO [15:0]); 0x10 COUNT (RO [15:0]). Unused bits SHALL read 0.
REQ-014 Writes SHALL occur only when iSUsiWCke=1, block selected and offset is 0x00; other writes SHALL be ignored.
REQ-015 oSUsiRd/oSUsiREd SHALL be registered: one cycle after a selected address, oSUsiREd=1 with the register value; unselected gives oSUsiREd=0, oSUsiRd=0. Unmapped offsets SHALL read 0 with oSUsiREd=1.
REQ-016 iPwm SHALL pass through a 2-FF synchronizer; edges are detected on the synchronized level (2-cycle input latency).
REQ-017 States SHALL be IDLE, ARM, MEASURE. enable=0 forces IDLE; enable=1 moves IDLE->ARM.
REQ-018 ARM: first synchronized rising edge -> MEASURE with cycle counter cnt=1; no capture.
REQ-019 MEASURE: cnt increments every cycle; on a falling edge, cnt is latched to an internal high register.
REQ-020 MEASURE rising edge: PERIOD<=cnt, HIGH<=internal high, valid<=1, COUNT<=COUNT+1 (wraps 0xFFFF->0), cnt<=1; all updates in the same cycle.
REQ-021 cnt SHALL saturate at 0xFFFF; on saturation stall<=1 and state->ARM without updating PERIOD/HIGH.
REQ-022 A rising edge with no falling edge since the previous capture (100% high) is impossible; if the input is constant low for a full period, this is covered by REQ-021.
REQ-023 valid and stall SHALL be sticky until a CTRL clear; if a clear and a capture coincide, the capture SHALL win (valid=1).
REQ-024 Clearing enable mid-measurement SHALL drop to IDLE, keeping PERIOD/HIGH/COUNT.

Reset
REQ-025 On iSysRst=1: state=IDLE, enable=0, valid=0, stall=0, cnt=0, PERIOD=HIGH=COUNT=0, synchronizer=0, oSUsiRd=0, oSUsiREd=0.
REQ-026 Reset asserted mid-operation SHALL take effect on the next clock edge with no partial capture.

Configuration
REQ-027 With PWM_CAPTURE_FILTER_EN defined, a 3-sample majority filter SHALL follow the synchronizer, adding 2 cycles of latency and rejecting pulses of 1 cycle or less.
REQ-028 Without PWM_CAPTURE_FILTER_EN, the synchronized level SHALL be used directly and 1-cycle pulses SHALL be measured.

Verification
REQ-029 Reset, then read 0x0304, 0x0308 and 0x0310 -> each returns 0 with oSUsiREd=1 one cycle later.
REQ-030 Write 1 to 0x0300, drive PWM with a 100-cycle period and 5 cycles high for 4 periods -> PERIOD=100, HIGH=5, valid=1, COUNT=3.
REQ-031 Capture running, then hold iPwm low for 70000 cycles -> stall=1; PERIOD/HIGH keep their last values. Resume PWM -> after ARM plus one period, PERIOD is valid again.
REQ-032 Write 3 to 0x0300 in the same cycle as a capturing rising edge -> valid=1; a later clear with no edge -> valid=0.
REQ-033 A 1-cycle-high pulse every 50 cycles -> with the filter, no capture; without it, PERIOD=50, HIGH=1.
REQ-034 Write to 0x0200 (other block) or to offset 0x08 -> CTRL is unchanged and no oSUsiREd is generated for 0x0200.
